// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared register-file types and constants for the core.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NUM_REGS = 32;

    localparam logic [AW-1:0] X0 = '0;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wq_entry_t;

endpackage
`default_nettype wire

// File: rtl/wq_lookup.sv
`default_nettype none
// ============================================================================
// Module      : wq_lookup
// Description : Combinational newest-match search over the write queue.
// Revision    : 1.0 - initial release
// ============================================================================
module wq_lookup #(
    parameter int  DEPTH = 4,
    parameter int  XLEN  = 32,
    parameter int  AW    = 5,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0][AW-1:0]   rds,
    input  logic [DEPTH-1:0][XLEN-1:0] datas,
    input  logic [PW-1:0]              head,
    input  logic [CW-1:0]              count,
    input  logic [AW-1:0]              q_addr,
    output logic                       hit,
    output logic [XLEN-1:0]            fwd
);

    // Walk oldest to newest so the last match (nearest the tail) wins.
    always_comb begin
        logic [PW-1:0] idx;
        hit = 1'b0;
        fwd = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (rds[idx] == q_addr) && (q_addr != '0)) begin
                hit = 1'b1;
                fwd = datas[idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_queue
// Description : In-order write buffer for the register file write port,
//               with forwarding lookup for the two decode read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_queue #(
    parameter int  DEPTH = 4,
    parameter int  XLEN  = rv_pkg::XLEN,
    parameter int  AW    = rv_pkg::AW,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_valid,
    input  logic [AW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            wr_hold,
    output logic            write_en,
    output logic [AW-1:0]   a3,
    output logic [XLEN-1:0] write_data,
    input  logic [AW-1:0]   q_a1,
    input  logic [AW-1:0]   q_a2,
    output logic            hit1,
    output logic            hit2,
    output logic [XLEN-1:0] fwd1,
    output logic [XLEN-1:0] fwd2,
    output logic            full,
    output logic            empty
);

    import rv_pkg::*;

    wq_entry_t            r_mem [DEPTH];
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [CW-1:0]        r_count;

    logic                 w_drain;
    logic                 w_space;
    logic                 w_ld_fire;
    logic                 w_alu_fire;
    logic                 w_enq;
    wq_entry_t            w_in;

    logic [DEPTH-1:0][AW-1:0]   w_rds;
    logic [DEPTH-1:0][XLEN-1:0] w_datas;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign w_drain   = !empty && !wr_hold;
    assign w_space   = !full || w_drain;
    assign ld_ready  = w_space;
    assign alu_ready = w_space && !ld_valid;

    assign w_ld_fire  = ld_valid && ld_ready;
    assign w_alu_fire = alu_valid && alu_ready;
    assign w_in.rd    = w_ld_fire ? ld_rd   : alu_rd;
    assign w_in.data  = w_ld_fire ? ld_data : alu_data;
    // Writes to x0 complete the handshake but are dropped here.
    assign w_enq      = (w_ld_fire || w_alu_fire) && (w_in.rd != X0);

    assign write_en   = w_drain;
    assign a3         = empty ? '0 : r_mem[r_head].rd;
    assign write_data = empty ? '0 : r_mem[r_head].data;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= w_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_drain) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign w_rds[g]   = r_mem[g].rd;
        assign w_datas[g] = r_mem[g].data;
    end

    wq_lookup #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) u_lookup1 (
        .rds    (w_rds),
        .datas  (w_datas),
        .head   (r_head),
        .count  (r_count),
        .q_addr (q_a1),
        .hit    (hit1),
        .fwd    (fwd1)
    );

    wq_lookup #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) u_lookup2 (
        .rds    (w_rds),
        .datas  (w_datas),
        .head   (r_head),
        .count  (r_count),
        .q_addr (q_a2),
        .hit    (hit2),
        .fwd    (fwd2)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_queue
// Description : Directed scoreboard bench for the register-file write queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_queue;

    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, alu_valid, wr_hold;
    logic [4:0]  ld_rd, alu_rd, q_a1, q_a2;
    logic [31:0] ld_data, alu_data;
    logic        ld_ready, alu_ready, write_en, hit1, hit2, full, empty;
    logic [4:0]  a3;
    logic [31:0] write_data, fwd1, fwd2;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    wq_entry_t exp_q [$];

    regfile_write_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .wr_hold    (wr_hold),
        .write_en   (write_en),
        .a3         (a3),
        .write_data (write_data),
        .q_a1       (q_a1),
        .q_a2       (q_a2),
        .hit1       (hit1),
        .hit2       (hit2),
        .fwd1       (fwd1),
        .fwd2       (fwd2),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Commit monitor: every write-port strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && write_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_a3", {27'd0, a3}, 32'hFFFF_FFFF);
            end else begin
                wq_entry_t e;
                e = exp_q.pop_front();
                chk("commit_a3", {27'd0, a3}, {27'd0, e.rd});
                chk("commit_data", write_data, e.data);
            end
        end
    end

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
        wq_entry_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                        input logic av, input logic [4:0] ard, input logic [31:0] adat,
                        input logic hold, input logic e_ldr, input logic e_alr);
        @(posedge clk);
        #1;
        ld_valid  = lv;   ld_rd  = lrd; ld_data  = ldat;
        alu_valid = av;   alu_rd = ard; alu_data = adat;
        wr_hold   = hold;
        @(negedge clk);
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, e_ldr});
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, e_alr});
        if (lv && e_ldr && lrd != 5'd0) push_exp(lrd, ldat);
        if (av && e_alr && ard != 5'd0) push_exp(ard, adat);
    endtask

    task automatic idle(input int n, input logic hold);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ld_valid  = 1'b0;
            alu_valid = 1'b0;
            wr_hold   = hold;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        wr_hold = 1'b0; q_a1 = '0; q_a2 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_write_en", {31'd0, write_en}, 32'd0);
        chk("rst_a3", {27'd0, a3}, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_hit1", {31'd0, hit1}, 32'd0);
        chk("rst_fwd1", fwd1, 32'd0);

        // Single load: visible on the write port one cycle later, then empty.
        step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);
        chk("lat_write_en", {31'd0, write_en}, 32'd1);
        idle(1, 1'b0);
        chk("lat_empty_after", {31'd0, empty}, 32'd1);

        // Load beats ALU in the same cycle; ALU goes next cycle.
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 1'b1, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h22, 1'b0, 1'b1, 1'b1);
        idle(3, 1'b0);

        // Fill under hold; fifth write waits for the first drain.
        for (int i = 0; i < 4; i++)
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(10 + i), 32'h100 + i, 1'b1, 1'b1, 1'b1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'h104, 1'b1, 1'b0, 1'b0);
        chk("hold_full", {31'd1 & 31'd0, full}, 32'd1);
        chk("hold_write_en", {31'd0, write_en}, 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'h104, 1'b0, 1'b1, 1'b1);
        idle(6, 1'b0);
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // Forwarding picks the newest of two writes to the same register.
        q_a1 = 5'd7;
        q_a2 = 5'd0;
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h2, 1'b1, 1'b1, 1'b1);
        idle(1, 1'b1);
        chk("fwd_hit1", {31'd0, hit1}, 32'd1);
        chk("fwd_fwd1", fwd1, 32'h2);
        chk("fwd_hit2", {31'd0, hit2}, 32'd0);
        chk("fwd_fwd2", fwd2, 32'd0);
        idle(4, 1'b0);
        chk("fwd_miss_after_drain", {31'd0, hit1}, 32'd0);

        // Write to x0 is accepted but never committed.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 1'b0, 1'b1, 1'b1);
        idle(3, 1'b0);
        chk("x0_empty", {31'd0, empty}, 32'd1);

        // Asynchronous reset with three entries queued.
        q_a1 = 5'd20;
        for (int i = 0; i < 3; i++)
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(20 + i), 32'h200 + i, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        wr_hold   = 1'b0;
        #1;
        chk("pre_rst_write_en", {31'd0, write_en}, 32'd1);
        chk("pre_rst_hit1", {31'd0, hit1}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_write_en", {31'd0, write_en}, 32'd0);
        chk("arst_a3", {27'd0, a3}, 32'd0);
        chk("arst_write_data", write_data, 32'd0);
        chk("arst_empty", {31'd0, empty}, 32'd1);
        chk("arst_hit1", {31'd0, hit1}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(5, 1'b0);
        chk("post_rst_empty", {31'd0, empty}, 32'd1);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
